// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Purpose : Shared types and constants for the two-requester APB arbiter.
//           Holds the master FSM state encoding, the fixed PPROT value and a
//           small helper that turns a requester index into a one-hot vector.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package apb_pkg;

  // APB master transfer phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Normal, secure, data access.
  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  // Requester index (0/1) to one-hot per-requester strobe.
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Purpose : Two-way round-robin grant selection (purely combinational).
//           When both requesters are valid the one not granted last wins;
//           a lone valid requester always wins.
// Ports   : i_valid[1:0]  - per-requester request
//           i_last_grant  - index of the requester granted most recently
//           o_grant       - index of the requester to grant now
//                           (don't-care when no requester is valid)
// ---------------------------------------------------------------------------
module apb_rr_arbiter
  import apb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant
);

  always_comb begin
    o_grant = 1'b0;
    if (i_valid == 2'b11) begin
      o_grant = ~i_last_grant;
    end else if (i_valid[1]) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
// Purpose : Arbitrates two simple request/response clients onto one APB
//           master port. A request is accepted in IDLE (req_ready pulses
//           combinationally), then the FSM runs SETUP and ACCESS and returns
//           a one-cycle rsp_valid pulse to the granted requester.
// Build option:
//   APB_ARBITER_TIMEOUT_EN - when defined, an ACCESS phase that sees
//                            pready=0 for TIMEOUT_CYCLES cycles is aborted
//                            and answered with rsp_err=1, rsp_rdata=0.
// Ports   : pclk, preset (async, active high)
//           req_valid/req_ready/req_write [1:0], req_addr [2*ADDR_WIDTH],
//           req_wdata [2*DATA_WIDTH] - requester side, slice n = requester n
//           rsp_valid [1:0], rsp_rdata, rsp_err - shared response bus
//           psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
//           pready, pslverr, prdata - APB master
// ---------------------------------------------------------------------------
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    pclk,
  input  logic                    preset,
  // requester side
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // APB master
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  // Reject configurations the byte-strobe output cannot represent.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("apb_arbiter: DATA_WIDTH must be a multiple of 8, TIMEOUT_CYCLES >= 1");
  end

  apb_state_t              r_state;
  logic                    r_last_grant;   // also the owner of the transfer in flight
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [1:0]              r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

  logic                    w_grant;
  logic                    w_accept;
  logic                    w_sel_write;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

`ifdef APB_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]        r_tmo_cnt;
`endif

  apb_rr_arbiter u_rr (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_accept    = (r_state == IDLE) && (req_valid != 2'b00);
  assign w_sel_write = req_write[w_grant];
  assign w_sel_addr  = w_grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : req_addr[ADDR_WIDTH-1:0];
  assign w_sel_wdata = w_grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];

  // Accept strobe is combinational so a requester sees acceptance in the
  // same cycle it is latched.
  assign req_ready = w_accept ? (req_onehot(w_grant) & req_valid) : 2'b00;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;  // requester 0 wins the first contention
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
`ifdef APB_ARBITER_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_rsp_valid <= 2'b00;  // response is a single-cycle pulse
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant;
            r_pwrite     <= w_sel_write;
            r_paddr      <= w_sel_addr;
            r_pwdata     <= w_sel_wdata;
            r_psel       <= 1'b1;
            r_penable    <= 1'b0;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_ARBITER_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= req_onehot(r_last_grant);
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= pslverr;
            r_state     <= IDLE;
          end
`ifdef APB_ARBITER_TIMEOUT_EN
          // This is the TIMEOUT_CYCLES-th stalled ACCESS cycle: give up.
          else if (r_tmo_cnt == TMO_LAST) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= req_onehot(r_last_grant);
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = '1;
  assign pprot     = PPROT_DEFAULT;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
// Purpose : Self-checking bench for apb_arbiter. A behavioural APB slave with
//           programmable wait states answers the DUT; a response scoreboard
//           holds the expected responses in order. A vector table covers
//           single transfers, then hand-written sequences cover back-to-back
//           contention, a withdrawn request, reset mid-transfer and (when
//           APB_ARBITER_TIMEOUT_EN is defined) the ACCESS timeout.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic            pclk = 1'b0;
  logic            preset;
  logic [1:0]      req_valid, req_ready, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic            pready, pslverr;
  logic [DW-1:0]   prdata;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  int            slv_wait = 0;
  int            acc_cnt  = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err  = 1'b0;

  assign prdata = slv_rdata;

  initial begin
    pready  = 1'b0;
    pslverr = 1'b0;
  end

  // Ready after slv_wait stalled ACCESS cycles.
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready  = (acc_cnt >= slv_wait);
      pslverr = pready & slv_err;
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // ---------------- response scoreboard ----------------
  typedef struct {
    int            req;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge pclk) begin
    if (rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b, expected no response", rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        $display("rsp: requester %0d rdata=%0h err=%0b (expected rdata=%0h err=%0b)",
                 rsp_valid[1], rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        chk("rsp_valid", rsp_valid, (mon_e.req == 1) ? 2'b10 : 2'b01);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err",   rsp_err,   mon_e.err);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int            req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_st;
    logic [DW-1:0] sdata;
    logic          serr;
    int            exp_pen;   // cycles with penable high
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  // One isolated transfer from a single requester, cycle-accurate checks.
  task automatic run_vec(input vec_t v);
    int pen;
    int rsp_cyc;
    logic [1:0] oh;
    oh = (v.req == 1) ? 2'b10 : 2'b01;
    @(negedge pclk);
    slv_wait  = v.wait_st;
    slv_rdata = v.sdata;
    slv_err   = v.serr;
    req_write[v.req]          = v.wr;
    req_addr[v.req*AW +: AW]  = v.addr;
    req_wdata[v.req*DW +: DW] = v.wdata;
    req_valid = oh;
    exp_q.push_back('{v.req, v.exp_rdata, v.exp_err});
    #1 chk("req_ready_accept", req_ready, oh);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    chk("setup_psel", psel, 1'b1);
    chk("setup_penable", penable, 1'b0);
    @(posedge pclk); #1;
    chk("access_psel", psel, 1'b1);
    chk("access_penable", penable, 1'b1);
    chk("paddr", paddr, v.addr);
    chk("pwrite", pwrite, v.wr);
    chk("pwdata", pwdata, v.wdata);
    chk("req_ready_busy", req_ready, 2'b00);
    pen = 1;
    rsp_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge pclk); #1;
      if (rsp_valid != 2'b00) begin
        rsp_cyc = c;
        break;
      end
      if (penable) pen++;
    end
    chk("rsp_latency", rsp_cyc, v.exp_pen - 1);
    chk("penable_cycles", pen, v.exp_pen);
    chk("psel_at_rsp", psel, 1'b0);
    @(posedge pclk); #1;
    chk("rsp_pulse_len", rsp_valid, 2'b00);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    int last_c;
    vec_t tv;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    preset    = 1'b1;

    // reset state
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("pstrb", pstrb, 1'b1);
    chk("pprot", pprot, 3'b000);
    preset = 1'b0;

    //          req wr   addr  wdata  wait sdata  serr pen rdata  err
    vecs[0] = '{0, 1'b1, 3'd3, 8'hA5, 0,   8'h77, 1'b0, 1, 8'h00, 1'b0};
    vecs[1] = '{1, 1'b0, 3'd3, 8'h12, 2,   8'hA5, 1'b0, 3, 8'hA5, 1'b0};
    vecs[2] = '{0, 1'b0, 3'd5, 8'h34, 0,   8'h3C, 1'b1, 1, 8'h3C, 1'b1};
    vecs[3] = '{1, 1'b1, 3'd7, 8'h5A, 1,   8'hEE, 1'b0, 2, 8'h00, 1'b0};
    vecs[4] = '{0, 1'b0, 3'd0, 8'h00, 3,   8'hFF, 1'b0, 4, 8'hFF, 1'b0};
    vecs[5] = '{1, 1'b1, 3'd1, 8'hC3, 0,   8'h99, 1'b1, 1, 8'h00, 1'b1};

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Request withdrawn before the clock edge is never granted.
    @(negedge pclk);
    req_valid = 2'b10;
    #1 chk("withdraw_ready", req_ready, 2'b10);
    #1 req_valid = 2'b00;
    @(posedge pclk); #1;
    chk("withdraw_no_psel", psel, 1'b0);

    // Continuous contention: last grant was requester 1, so order 0,1,0,1
    // with each accept landing in the cycle of the previous response.
    slv_wait  = 0;
    slv_rdata = 8'h11;
    slv_err   = 1'b0;
    req_write = 2'b00;
    req_addr  = {3'd6, 3'd2};
    for (int k = 0; k < 4; k++) exp_q.push_back('{k % 2, 8'h11, 1'b0});
    @(negedge pclk);
    req_valid = 2'b11;
    acc = 0;
    last_c = 0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      if (c > 0) @(negedge pclk);
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", req_ready, (acc % 2 == 1) ? 2'b10 : 2'b01);
        if (acc > 0) begin
          chk("rr_b2b_rsp", rsp_valid != 2'b00, 1'b1);
          chk("rr_accept_gap", c - last_c, 3);
        end
        last_c = c;
        acc++;
      end
    end
    @(posedge pclk); #1;
    req_valid = 2'b00;
    chk("rr_accepts", acc, 4);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge pclk);
    #1 chk("rr_drain", exp_q.size(), 0);

`ifdef APB_ARBITER_TIMEOUT_EN
    tv = '{0, 1'b0, 3'd4, 8'h00, 1000, 8'h5C, 1'b0, 15, 8'h00, 1'b1};
    run_vec(tv);
    slv_wait = 0;
`endif

    // Reset during ACCESS of a requester-0 transfer: no response, and the
    // grant pointer returns so requester 0 wins the next contention.
    tv = '{0, 1'b0, 3'd2, 8'h00, 1000, 8'h42, 1'b0, 1, 8'h00, 1'b0};
    @(negedge pclk);
    slv_wait  = tv.wait_st;
    slv_rdata = tv.sdata;
    req_addr[AW-1:0] = tv.addr;
    req_valid = 2'b01;
    @(posedge pclk); #1;
    req_valid = 2'b00;
    @(posedge pclk); #1;
    chk("abort_in_access", penable, 1'b1);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("abort_psel", psel, 1'b0);
    chk("abort_penable", penable, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 2'b00);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset   = 1'b0;
    slv_wait = 0;
    exp_q.push_back('{0, 8'h42, 1'b0});
    req_valid = 2'b11;
    #1 chk("post_rst_grant", req_ready, 2'b01);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge pclk);
    #1 chk("post_rst_drain", exp_q.size(), 0);
    repeat (3) @(posedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
